// File: rtl/opendap_ap_pkg.sv
// Shared definitions for the OpenDAP access ports.
// Holds the AP register index map, CSW field positions, AddrInc encodings,
// the APB master FSM state encoding and a CSW read-value helper.
package opendap_ap_pkg;

    // Register indices as seen on ap_addr (address bits [7:2])
    localparam logic [5:0] AP_CSW  = 6'h00;
    localparam logic [5:0] AP_TAR  = 6'h01;
    localparam logic [5:0] AP_DRW  = 6'h03;
    localparam logic [5:0] AP_BD0  = 6'h04;
    localparam logic [5:0] AP_BD1  = 6'h05;
    localparam logic [5:0] AP_BD2  = 6'h06;
    localparam logic [5:0] AP_BD3  = 6'h07;
    localparam logic [5:0] AP_CFG  = 6'h3D;
    localparam logic [5:0] AP_BASE = 6'h3E;
    localparam logic [5:0] AP_IDR  = 6'h3F;

    // CSW field positions
    localparam int CSW_SIZE_LSB     = 0;
    localparam int CSW_ADDRINC_LSB  = 4;
    localparam int CSW_DEVEN_BIT    = 6;
    localparam int CSW_TRINPROG_BIT = 7;

    localparam logic [2:0] CSW_SIZE_WORD = 3'b010;

    // AddrInc encodings; 1x is reserved and behaves as off
    localparam logic [1:0] ADDRINC_OFF    = 2'b00;
    localparam logic [1:0] ADDRINC_SINGLE = 2'b01;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

    // CSW as returned on a read: fixed word size, device always enabled
    function automatic logic [31:0] csw_value(input logic [1:0] addr_inc,
                                              input logic       busy);
        logic [31:0] v;
        v = '0;
        v[CSW_SIZE_LSB +: 3]    = CSW_SIZE_WORD;
        v[CSW_ADDRINC_LSB +: 2] = addr_inc;
        v[CSW_DEVEN_BIT]        = 1'b1;
        v[CSW_TRINPROG_BIT]     = busy;
        return v;
    endfunction

endpackage

// File: rtl/opendap_apb_master.sv
// APB3 master engine for the MEM-AP.
// Runs one IDLE -> SETUP -> ACCESS transfer per start pulse. Address, data and
// direction are captured on the start edge and held until the transfer ends.
// Ports:
//   swclk, rst_n          clock, async active-low reset
//   start                 launch a transfer (only honoured in IDLE)
//   start_write/addr/wdata  transfer attributes captured with start
//   busy                  registered, high from the cycle after start until completion
//   done                  combinational: completion is sampled at this edge
//   err                   registered one-cycle pslverr report, aligned with busy falling
//   paddr/psel/penable/pwrite/pwdata  APB request (registered)
//   pready, pslverr       APB response
module opendap_apb_master
    import opendap_ap_pkg::*;
(
    input  logic        swclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        start_write,
    input  logic [31:0] start_addr,
    input  logic [31:0] start_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic        pslverr
);

    apb_state_t state;

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= APB_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                APB_IDLE: begin
                    if (start) begin
                        state   <= APB_SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= start_write;
                        paddr   <= start_addr;
                        pwdata  <= start_wdata;
                        busy    <= 1'b1;
                    end
                end
                APB_SETUP: begin
                    state   <= APB_ACCESS;
                    penable <= 1'b1;
                end
                APB_ACCESS: begin
                    if (pready) begin
                        state   <= APB_IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        busy    <= 1'b0;
                        err     <= pslverr;
                    end
                end
                default: begin
                    state   <= APB_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // The top uses this to capture read data and bump TAR on the same edge
    // that the FSM leaves ACCESS.
    assign done = (state == APB_ACCESS) && pready;

endmodule

// File: rtl/opendap_mem_ap_apb.sv
// MEM-AP on the SW-DP AP bus, bridging DRW/BDx accesses to 32-bit APB3.
// Register file (CSW, TAR, CFG, BASE, IDR) and TAR auto-increment live here;
// the APB handshake is in opendap_apb_master.
// Build option: define OPENDAP_MEM_AP_BD_EN to implement BD0-BD3; otherwise
// those indices are RAZ/WI and never touch APB.
// Ports:
//   swclk, rst_n                 clock, async active-low reset
//   ap_sel, ap_addr, ap_wdata    AP access selector, register index, write data
//   ap_wen, ap_ren               one-cycle access strobes
//   ap_rdata                     last completed read result
//   ap_rdy                       idle, ready for the next access
//   ap_err                       one-cycle error pulse at completion
//   paddr/psel/penable/pwrite/pwdata/prdata/pready/pslverr  APB3 master
module opendap_mem_ap_apb
    import opendap_ap_pkg::*;
#(
    parameter logic [7:0]  AP_INDEX = 8'd0,
    parameter logic [31:0] IDR      = 32'h0477_0001,
    parameter logic [31:0] BASE     = 32'h0000_0003
) (
    input  logic        swclk,
    input  logic        rst_n,
    input  logic [7:0]  ap_sel,
    input  logic [5:0]  ap_addr,
    input  logic [31:0] ap_wdata,
    input  logic        ap_wen,
    input  logic        ap_ren,
    output logic [31:0] ap_rdata,
    output logic        ap_rdy,
    output logic        ap_err,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    logic [31:0] tar;
    logic [1:0]  addr_inc;
    logic        xfer_drw;     // current transfer came from DRW (may bump TAR)
    logic        busy;
    logic        done;
    logic        is_bd;
    logic        is_mem;
    logic        sel_hit;
    logic        strobe;
    logic        start;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] mem_addr;
    logic [31:0] reg_rdata;

`ifdef OPENDAP_MEM_AP_BD_EN
    assign is_bd = (ap_addr[5:2] == AP_BD0[5:2]);
`else
    assign is_bd = 1'b0;
`endif

    assign ap_rdy  = !busy;
    assign sel_hit = (ap_sel == AP_INDEX);
    // Strobes arriving mid-transfer are dropped entirely
    assign strobe  = (ap_wen || ap_ren) && ap_rdy;
    assign is_mem  = (ap_addr == AP_DRW) || is_bd;
    assign start   = strobe && sel_hit && is_mem;
    assign reg_wr  = strobe && sel_hit && !is_mem && ap_wen;
    // Unselected reads still complete and return zero
    assign reg_rd  = strobe && ap_ren && !(sel_hit && is_mem);

    // BDn replaces TAR[3:2] with n; DRW uses TAR word-aligned
    assign mem_addr = is_bd ? {tar[31:4], ap_addr[1:0], 2'b00}
                            : {tar[31:2], 2'b00};

    always_comb begin
        reg_rdata = '0;
        case (ap_addr)
            AP_CSW:  reg_rdata = csw_value(addr_inc, busy);
            AP_TAR:  reg_rdata = tar;
            AP_CFG:  reg_rdata = '0;
            AP_BASE: reg_rdata = BASE;
            AP_IDR:  reg_rdata = IDR;
            default: reg_rdata = '0;
        endcase
    end

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            tar      <= '0;
            addr_inc <= ADDRINC_OFF;
            ap_rdata <= '0;
            xfer_drw <= 1'b0;
        end else begin
            if (start)
                xfer_drw <= !is_bd;
            if (reg_wr) begin
                if (ap_addr == AP_CSW)
                    addr_inc <= ap_wdata[CSW_ADDRINC_LSB +: 2];
                else if (ap_addr == AP_TAR)
                    tar <= ap_wdata;
            end
            if (reg_rd)
                ap_rdata <= sel_hit ? reg_rdata : '0;
            // done only fires while busy, so it never collides with a strobe
            if (done) begin
                if (!pwrite)
                    ap_rdata <= prdata;
                // Increment stays inside the 1 KB block: only TAR[9:2] moves
                if (xfer_drw && (addr_inc == ADDRINC_SINGLE) && !pslverr)
                    tar[9:2] <= tar[9:2] + 8'd1;
            end
        end
    end

    opendap_apb_master u_apb (
        .swclk       (swclk),
        .rst_n       (rst_n),
        .start       (start),
        .start_write (ap_wen),
        .start_addr  (mem_addr),
        .start_wdata (ap_wdata),
        .busy        (busy),
        .done        (done),
        .err         (ap_err),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

endmodule

// File: tb/tb_opendap_mem_ap_apb.sv
// Self-checking bench for opendap_mem_ap_apb: directed scenarios followed by
// randomized AP traffic, checked against a transaction-level model of the
// register map, TAR increment and APB transfers.
module tb_opendap_mem_ap_apb;

    localparam logic [7:0]  AP_IDX = 8'h02;
    localparam logic [31:0] IDR_P  = 32'h0477_0001;
    localparam logic [31:0] BASE_P = 32'h0000_0003;
`ifdef OPENDAP_MEM_AP_BD_EN
    localparam bit BD_EN = 1'b1;
`else
    localparam bit BD_EN = 1'b0;
`endif

    logic        swclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ap_sel = '0;
    logic [5:0]  ap_addr = '0;
    logic [31:0] ap_wdata = '0;
    logic        ap_wen = 1'b0;
    logic        ap_ren = 1'b0;
    logic [31:0] ap_rdata;
    logic        ap_rdy;
    logic        ap_err;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    always #5 swclk = ~swclk;

    opendap_mem_ap_apb #(.AP_INDEX(AP_IDX), .IDR(IDR_P), .BASE(BASE_P)) dut (
        .swclk(swclk), .rst_n(rst_n),
        .ap_sel(ap_sel), .ap_addr(ap_addr), .ap_wdata(ap_wdata),
        .ap_wen(ap_wen), .ap_ren(ap_ren),
        .ap_rdata(ap_rdata), .ap_rdy(ap_rdy), .ap_err(ap_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // ---------------- APB slave ----------------
    int          cfg_wait = 0;
    bit          cfg_err = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          wait_left = 0;
    int          unstable_cnt = 0;
    logic [31:0] setup_addr, setup_wd;
    logic        setup_wr;
    logic [31:0] log_addr[$];
    logic        log_wr[$];
    logic [31:0] log_wd[$];

    assign pready  = psel && penable && (wait_left == 0);
    assign prdata  = cfg_rdata;
    assign pslverr = cfg_err;

    always @(posedge swclk) begin
        if (psel && !penable) begin
            wait_left  <= cfg_wait;
            setup_addr <= paddr;
            setup_wd   <= pwdata;
            setup_wr   <= pwrite;
        end else if (psel && penable) begin
            if (wait_left > 0) wait_left <= wait_left - 1;
            if (paddr !== setup_addr || pwdata !== setup_wd || pwrite !== setup_wr)
                unstable_cnt <= unstable_cnt + 1;
        end
        if (psel && penable && pready) begin
            log_addr.push_back(paddr);
            log_wr.push_back(pwrite);
            log_wd.push_back(pwdata);
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int err_busy = 0;
    bit poke_csw = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_tar = '0;
    logic [1:0]  m_inc = '0;
    logic [31:0] m_rdata = '0;

    function automatic logic [31:0] exp_reg(input logic [5:0] a);
        case (a)
            6'h00:   return 32'h0000_0042 | (32'(m_inc) << 4);
            6'h01:   return m_tar;
            6'h3E:   return BASE_P;
            6'h3F:   return IDR_P;
            default: return 32'h0;
        endcase
    endfunction

    // Drive one strobe and wait (bounded) until the AP is ready again.
    task automatic ap_access(input bit wr, input logic [5:0] addr, input logic [31:0] wd,
                             input logic [7:0] sel, output int busy, output bit err,
                             output bit err2);
        @(negedge swclk);
        ap_sel = sel; ap_addr = addr; ap_wdata = wd; ap_wen = wr; ap_ren = !wr;
        @(negedge swclk);
        ap_wen = 1'b0; ap_ren = 1'b0;
        busy = 0;
        while (!ap_rdy && busy < 100) begin
            if (ap_err) err_busy++;
            // an access attempted mid-transfer must be ignored
            ap_ren = poke_csw && (busy == 1);
            if (ap_ren) ap_addr = 6'h00;
            busy++;
            @(negedge swclk);
        end
        ap_ren = 1'b0;
        err = ap_err;
        err2 = 1'b0;
        if (busy > 0) begin
            @(negedge swclk);
            err2 = ap_err;
        end
    endtask

    task automatic model_op(input bit wr, input logic [5:0] addr, input logic [31:0] wd,
                            input logic [7:0] sel, input int waits, input bit perr,
                            input logic [31:0] rd);
        bit sel_ok, is_mem, err, err2;
        logic [31:0] e_paddr, e_rdata, a, d;
        logic w;
        int n0, busy;
        sel_ok = (sel == AP_IDX);
        is_mem = sel_ok && (addr == 6'h03 || (BD_EN && addr >= 6'h04 && addr <= 6'h07));
        cfg_wait = waits; cfg_err = perr; cfg_rdata = rd;
        n0 = log_addr.size();
        e_rdata = m_rdata;
        e_paddr = '0;
        if (is_mem) begin
            if (addr == 6'h03) e_paddr = m_tar & ~32'h3;
            else               e_paddr = (m_tar & ~32'hF) | (32'(addr - 6'd4) << 2);
            if (!wr) e_rdata = rd;
            if (addr == 6'h03 && m_inc == 2'b01 && !perr)
                m_tar = (m_tar & ~32'h3FC) | ((m_tar + 32'd4) & 32'h3FC);
        end else if (sel_ok && wr) begin
            if (addr == 6'h00)      m_inc = wd[5:4];
            else if (addr == 6'h01) m_tar = wd;
        end else if (!wr) begin
            e_rdata = sel_ok ? exp_reg(addr) : 32'h0;
        end
        ap_access(wr, addr, wd, sel, busy, err, err2);
        chk("busy_cycles", 32'(busy), is_mem ? 32'(2 + waits) : 32'd0);
        chk("ap_err", {31'd0, err}, {31'd0, is_mem && perr});
        if (is_mem) chk("ap_err_len", {31'd0, err2}, 32'd0);
        chk("ap_rdata", ap_rdata, e_rdata);
        chk("apb_count", 32'(log_addr.size() - n0), {31'd0, is_mem});
        if (is_mem && log_addr.size() > n0) begin
            a = log_addr.pop_front(); w = log_wr.pop_front(); d = log_wd.pop_front();
            chk("paddr", a, e_paddr);
            chk("pwrite", {31'd0, w}, {31'd0, wr});
            if (wr) chk("pwdata", d, wd);
        end
        m_rdata = e_rdata;
    endtask

    initial begin
        int op, w;
        bit pe;
        logic [5:0] ra;

        // reset state
        repeat (3) @(negedge swclk);
        chk("rst_ap_rdata", ap_rdata, 32'h0);
        chk("rst_ap_rdy", {31'd0, ap_rdy}, 32'd1);
        chk("rst_ap_err", {31'd0, ap_err}, 32'd0);
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        rst_n = 1'b1;
        model_op(0, 6'h00, 0, AP_IDX, 0, 0, 0);
        chk("csw_reset", ap_rdata, 32'h0000_0042);

        // incrementing DRW writes
        model_op(1, 6'h01, 32'h2000_0000, AP_IDX, 0, 0, 0);
        model_op(1, 6'h00, 32'h0000_0010, AP_IDX, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            model_op(1, 6'h03, 32'(i + 1) * 32'h11, AP_IDX, 0, 0, 0);
        model_op(0, 6'h01, 0, AP_IDX, 0, 0, 0);
        chk("tar_after_4", ap_rdata, 32'h2000_0010);

        // 1 KB wrap on read
        model_op(1, 6'h01, 32'h2000_03FC, AP_IDX, 0, 0, 0);
        model_op(0, 6'h03, 0, AP_IDX, 0, 0, 32'hCAFE_F00D);
        chk("wrap_rdata", ap_rdata, 32'hCAFE_F00D);
        model_op(0, 6'h01, 0, AP_IDX, 0, 0, 0);
        chk("tar_wrap", ap_rdata, 32'h2000_0000);

        // wait states, with an ignored CSW read attempted while busy
        poke_csw = 1'b1;
        model_op(1, 6'h03, 32'hDEAD_BEEF, AP_IDX, 5, 0, 0);
        poke_csw = 1'b0;

        // slave error: ap_err pulse, no TAR increment
        model_op(0, 6'h03, 0, AP_IDX, 1, 1, 32'h1234_5678);
        model_op(0, 6'h01, 0, AP_IDX, 0, 0, 0);

        // other AP selected
        model_op(0, 6'h3F, 0, AP_IDX, 0, 0, 0);
        chk("idr", ap_rdata, IDR_P);
        model_op(1, 6'h01, 32'h5555_0000, AP_IDX + 8'd1, 0, 0, 0);
        model_op(0, 6'h3F, 0, AP_IDX + 8'd1, 0, 0, 0);
        model_op(0, 6'h3E, 0, AP_IDX, 0, 0, 0);
        model_op(0, 6'h3D, 0, AP_IDX, 0, 0, 0);
        model_op(0, 6'h01, 0, AP_IDX, 0, 0, 0);

        // banked data (or RAZ/WI when not built in)
        model_op(1, 6'h01, 32'h0000_0100, AP_IDX, 0, 0, 0);
        model_op(0, 6'h06, 0, AP_IDX, 0, 0, 32'hB0B0_0002);
        model_op(1, 6'h05, 32'hA5A5_0001, AP_IDX, 2, 0, 0);
        model_op(0, 6'h01, 0, AP_IDX, 0, 0, 0);

        // reset during ACCESS
        model_op(1, 6'h00, 32'h10, AP_IDX, 0, 0, 0);
        cfg_wait = 5; cfg_err = 1'b0;
        @(negedge swclk);
        ap_sel = AP_IDX; ap_addr = 6'h03; ap_wdata = 32'h7777_7777; ap_wen = 1'b1;
        @(negedge swclk);
        ap_wen = 1'b0;
        @(negedge swclk);
        chk("mid_penable", {31'd0, penable}, 32'd1);
        @(posedge swclk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_psel", {31'd0, psel}, 32'd0);
        chk("arst_penable", {31'd0, penable}, 32'd0);
        chk("arst_ap_rdy", {31'd0, ap_rdy}, 32'd1);
        @(negedge swclk);
        rst_n = 1'b1;
        m_tar = '0; m_inc = '0; m_rdata = '0;
        chk("arst_rdata", ap_rdata, 32'h0);
        model_op(0, 6'h01, 0, AP_IDX, 0, 0, 0);
        model_op(0, 6'h00, 0, AP_IDX, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 7);
            w  = $urandom_range(0, 3);
            pe = ($urandom_range(0, 7) == 0);
            case (op)
                0: model_op(1, 6'h01, $urandom, AP_IDX, 0, 0, 0);
                1: model_op(1, 6'h00, $urandom, AP_IDX, 0, 0, 0);
                2: model_op(1, 6'h03, $urandom, AP_IDX, w, pe, 0);
                3: model_op(0, 6'h03, 0, AP_IDX, w, pe, $urandom);
                4: begin
                    ra = 6'($urandom_range(0, 63));
                    model_op(0, ra, 0, AP_IDX, w, pe, $urandom);
                end
                5: begin
                    ra = 6'($urandom_range(0, 63));
                    model_op($urandom_range(0, 1) == 1, ra, $urandom,
                             AP_IDX ^ 8'(1 << $urandom_range(0, 7)), w, pe, $urandom);
                end
                6: model_op($urandom_range(0, 1) == 1, 6'(4 + $urandom_range(0, 3)),
                            $urandom, AP_IDX, w, pe, $urandom);
                default: model_op(0, 6'h01, 0, AP_IDX, 0, 0, 0);
            endcase
        end
        model_op(0, 6'h01, 0, AP_IDX, 0, 0, 0);

        chk("apb_stable", 32'(unstable_cnt), 32'd0);
        chk("err_while_busy", 32'(err_busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
